// File: rtl/dcsk_pkg.sv
// Shared DCSK definitions: default geometry, FSM state encoding and chip negation.
// Optional build macro DCSK_SAT_NEG_EN makes negating the most-negative chip saturate.
package dcsk_pkg;

    localparam int DEFAULT_SPREAD_FACTOR = 2;
    localparam int DEFAULT_CHIP_W        = 8;
    localparam int MAX_CHIP_W            = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REF  = 2'd1,
        ST_DATA = 2'd2
    } dcsk_state_e;

    // v is a w-bit chip sign-extended to MAX_CHIP_W; the caller keeps the low w bits.
    function automatic logic signed [MAX_CHIP_W-1:0] dcsk_negate(
        input logic signed [MAX_CHIP_W-1:0] v,
        input int                           w
    );
        logic signed [MAX_CHIP_W-1:0] min_v;
        min_v = '1;
        min_v = min_v << (w - 1);
        if (v == min_v) begin
`ifdef DCSK_SAT_NEG_EN
            return ~min_v;
`else
            return min_v;
`endif
        end
        return -v;
    endfunction

endpackage

// File: rtl/dcsk_symbol_modulator_if.sv
// Chaos-source, data-bit and chip-output signals of the DCSK symbol modulator.
// slave = modulator view, master = the environment driving it.
interface dcsk_symbol_modulator_if
    import dcsk_pkg::*;
#(
    parameter int SPREAD_FACTOR = DEFAULT_SPREAD_FACTOR,
    parameter int CHIP_W        = DEFAULT_CHIP_W
);
    localparam int IDX_W = $clog2(2 * SPREAD_FACTOR);

    logic signed [CHIP_W-1:0] chaos_data;
    logic                     chaos_empty;
    logic                     chaos_rd;
    logic                     bit_valid;
    logic                     bit_in;
    logic                     bit_ready;
    logic signed [CHIP_W-1:0] chip_out;
    logic                     chip_valid;
    logic [IDX_W-1:0]         chip_index;
    logic                     sym_done;

    modport slave (
        input  chaos_data, chaos_empty, bit_valid, bit_in,
        output chaos_rd, bit_ready, chip_out, chip_valid, chip_index, sym_done
    );

    modport master (
        output chaos_data, chaos_empty, bit_valid, bit_in,
        input  chaos_rd, bit_ready, chip_out, chip_valid, chip_index, sym_done
    );

endinterface

// File: rtl/dcsk_ref_buffer.sv
// Reference-chip register file: one write port and one asynchronous read port,
// indexed by chip position within the half-symbol; cleared on reset.
module dcsk_ref_buffer
    import dcsk_pkg::*;
#(
    parameter int DEPTH = DEFAULT_SPREAD_FACTOR,
    parameter int WIDTH = DEFAULT_CHIP_W,
    parameter int IDX_W = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [WIDTH-1:0] rd_data
);

    logic [DEPTH*WIDTH-1:0] slots_flat;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_q;
            logic [WIDTH-1:0] slot_d;

            always_comb begin
                slot_d = slot_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    slot_d = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign slots_flat[gi*WIDTH +: WIDTH] = slot_q;
        end
    endgenerate

    assign rd_data = slots_flat[rd_idx*WIDTH +: WIDTH];

endmodule

// File: rtl/dcsk_symbol_modulator.sv
// DCSK symbol modulator: pops SPREAD_FACTOR chaos chips as the reference half, then
// replays them (negated for bit 0) as the data half. Build macro: DCSK_SAT_NEG_EN.
module dcsk_symbol_modulator
    import dcsk_pkg::*;
#(
    parameter int SPREAD_FACTOR = DEFAULT_SPREAD_FACTOR,
    parameter int CHIP_W        = DEFAULT_CHIP_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    dcsk_symbol_modulator_if.slave  bus
);

    localparam int IDX_W = $clog2(2 * SPREAD_FACTOR);
    localparam int K_W   = (SPREAD_FACTOR > 1) ? $clog2(SPREAD_FACTOR) : 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REF  = ST_REF;
    localparam logic [1:0] DATA = ST_DATA;

    logic [1:0]               state_q,      state_d;
    logic                     bit_q,        bit_d;
    logic [K_W-1:0]           k_q,          k_d;
    logic signed [CHIP_W-1:0] chip_out_q,   chip_out_d;
    logic                     chip_valid_q, chip_valid_d;
    logic [IDX_W-1:0]         chip_index_q, chip_index_d;
    logic                     sym_done_q,   sym_done_d;

    logic                     buf_wr;
    logic signed [CHIP_W-1:0] buf_rd_data;
    logic signed [CHIP_W-1:0] chip_neg;
    logic                     chaos_rd;
    logic                     bit_ready;
    logic                     k_last;

    dcsk_ref_buffer #(
        .DEPTH (SPREAD_FACTOR),
        .WIDTH (CHIP_W),
        .IDX_W (K_W)
    ) u_ref_buffer (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (buf_wr),
        .wr_idx  (k_q),
        .wr_data (bus.chaos_data),
        .rd_idx  (k_q),
        .rd_data (buf_rd_data)
    );

    assign k_last   = (k_q == K_W'(SPREAD_FACTOR - 1));
    assign chip_neg = CHIP_W'(dcsk_negate(MAX_CHIP_W'(buf_rd_data), CHIP_W));

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        k_d          = k_q;
        chip_out_d   = chip_out_q;
        chip_valid_d = 1'b0;
        chip_index_d = chip_index_q;
        sym_done_d   = 1'b0;
        buf_wr       = 1'b0;
        chaos_rd     = 1'b0;
        bit_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                bit_ready = 1'b1;
                k_d       = '0;
                if (bus.bit_valid) begin
                    bit_d   = bus.bit_in;
                    state_d = REF;
                end
            end
            REF: begin
                // An empty chaos source simply stalls the reference half.
                chaos_rd = ~bus.chaos_empty;
                if (!bus.chaos_empty) begin
                    buf_wr       = 1'b1;
                    chip_out_d   = bus.chaos_data;
                    chip_valid_d = 1'b1;
                    chip_index_d = IDX_W'(k_q);
                    if (k_last) begin
                        k_d     = '0;
                        state_d = DATA;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            DATA: begin
                chip_out_d   = bit_q ? buf_rd_data : chip_neg;
                chip_valid_d = 1'b1;
                chip_index_d = IDX_W'(SPREAD_FACTOR) + IDX_W'(k_q);
                if (k_last) begin
                    k_d        = '0;
                    sym_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            bit_q        <= 1'b0;
            k_q          <= '0;
            chip_out_q   <= '0;
            chip_valid_q <= 1'b0;
            chip_index_q <= '0;
            sym_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            k_q          <= k_d;
            chip_out_q   <= chip_out_d;
            chip_valid_q <= chip_valid_d;
            chip_index_q <= chip_index_d;
            sym_done_q   <= sym_done_d;
        end
    end

    assign bus.chaos_rd   = chaos_rd;
    assign bus.bit_ready  = bit_ready;
    assign bus.chip_out   = chip_out_q;
    assign bus.chip_valid = chip_valid_q;
    assign bus.chip_index = chip_index_q;
    assign bus.sym_done   = sym_done_q;

endmodule

// File: tb/tb_dcsk_symbol_modulator.sv
// Scoreboard bench for dcsk_symbol_modulator (SPREAD_FACTOR=2, CHIP_W=8); expected chips
// are queued when a bit is accepted and compared as chip_valid outputs appear.
module tb_dcsk_symbol_modulator;

    localparam int SF = 2;
    localparam int CW = 8;

    typedef struct {
        int chip;
        int idx;
        int done;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    dcsk_symbol_modulator_if #(.SPREAD_FACTOR(SF), .CHIP_W(CW)) bus ();

    dcsk_symbol_modulator #(.SPREAD_FACTOR(SF), .CHIP_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    exp_t sb_q[$];
    int   chaos_q[$];
    int   bits_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit stall_armed   = 0;
    bit stall_chk     = 0;
    bit abort_armed   = 0;
    bit post_rst_chk  = 0;
    bit gap_chk_en    = 0;
    int stall_left    = 0;
    int last_done_cyc = -1;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Chip negation as seen on the wire: -(-128) is either saturated or wraps back.
    function automatic int exp_neg(input int v);
        if (v == -128) begin
`ifdef DCSK_SAT_NEG_EN
            return 127;
`else
            return -128;
`endif
        end
        return -v;
    endfunction

    task automatic run_cycle();
        exp_t e;
        int   b;
        @(negedge clk);
        cyc++;
        if (post_rst_chk) begin
            check("rst_abort_valid", bus.chip_valid, 0);
            check("rst_abort_index", bus.chip_index, 0);
            check("rst_abort_ready", bus.bit_ready, 1);
            post_rst_chk = 0;
            rstn = 1'b1;
        end
        if (stall_chk) begin
            check("stall_valid", bus.chip_valid, 0);
            stall_chk = 0;
        end
        if (bus.chip_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_chip", 1, 0);
            end else begin
                e = sb_q.pop_front();
                if (gap_chk_en && e.idx == 0 && last_done_cyc >= 0)
                    check("sym_gap", cyc - last_done_cyc, 2);
                check("chip_out", $signed(bus.chip_out), e.chip);
                check("chip_index", bus.chip_index, e.idx);
                check("sym_done", bus.sym_done, e.done);
                $display("chip %0d idx %0d done %0d (cycle %0d)", $signed(bus.chip_out), bus.chip_index, bus.sym_done, cyc);
                if (bus.sym_done) last_done_cyc = cyc;
                if (abort_armed && e.idx == 2) begin
                    abort_armed = 0;
                    sb_q.delete();
                    rstn = 1'b0;
                    post_rst_chk = 1;
                end
            end
        end else if (bus.sym_done) begin
            check("done_without_valid", 1, 0);
        end

        bus.chaos_empty = (chaos_q.size() == 0) || (stall_left > 0);
        bus.chaos_data  = (chaos_q.size() > 0) ? 8'(chaos_q[0]) : '0;
        bus.bit_valid   = (bits_q.size() > 0) && rstn;
        bus.bit_in      = (bits_q.size() > 0) ? (bits_q[0] != 0) : 1'b0;
        #1;
        if (stall_left > 0) begin
            check("stall_rd", bus.chaos_rd, 0);
            stall_left--;
            stall_chk = 1;
        end
        if (bus.chaos_rd && !bus.chaos_empty) begin
            void'(chaos_q.pop_front());
            if (stall_armed) begin
                stall_armed = 0;
                stall_left  = 3;
            end
        end
        if (bus.bit_valid && bus.bit_ready) begin
            b = bits_q.pop_front();
            if (chaos_q.size() < SF) check("chaos_underrun", chaos_q.size(), SF);
            for (int i = 0; i < SF && i < chaos_q.size(); i++)
                sb_q.push_back('{chip: chaos_q[i], idx: i, done: 0});
            for (int i = 0; i < SF && i < chaos_q.size(); i++)
                sb_q.push_back('{chip: (b != 0) ? chaos_q[i] : exp_neg(chaos_q[i]),
                                 idx: SF + i, done: (i == SF - 1) ? 1 : 0});
            $display("bit %0d accepted (cycle %0d)", b, cyc);
        end
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() > 0 || bits_q.size() > 0 || post_rst_chk) && n < budget) begin
            run_cycle();
            n++;
        end
        if (n >= budget) begin
            check("timeout", 1, 0);
            sb_q.delete();
            bits_q.delete();
        end
        repeat (2) run_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.chaos_data  = '0;
        bus.chaos_empty = 1'b1;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
        rstn            = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_chip_out", $signed(bus.chip_out), 0);
        check("reset_valid", bus.chip_valid, 0);
        check("reset_index", bus.chip_index, 0);
        check("reset_done", bus.sym_done, 0);
        check("reset_ready", bus.bit_ready, 1);
        check("reset_rd", bus.chaos_rd, 0);
        rstn = 1'b1;

        // Basic symbols, both polarities
        chaos_q = '{10, -20}; bits_q = '{1}; run_until_done(50);
        chaos_q = '{10, -20}; bits_q = '{0}; run_until_done(50);

        // Chaos source empty for 3 cycles after the first reference pop
        stall_armed = 1;
        chaos_q = '{7, -3}; bits_q = '{1}; run_until_done(50);

        // Most-negative chip under negation
        chaos_q = '{-128, 5}; bits_q = '{0}; run_until_done(50);

        // Reset while the data half is on the wire, then a clean symbol
        abort_armed = 1;
        chaos_q = '{30, 40, 50, -60}; bits_q = '{1, 0}; run_until_done(60);

        // Back-to-back bits
        gap_chk_en = 1; last_done_cyc = -1;
        chaos_q = '{1, 2, 3, 4}; bits_q = '{1, 0}; run_until_done(60);
        gap_chk_en = 0;

        // Random symbols
        for (int s = 0; s < 6; s++) begin
            chaos_q.push_back(int'($urandom_range(0, 255)) - 128);
            chaos_q.push_back(int'($urandom_range(0, 255)) - 128);
            bits_q.push_back(int'($urandom_range(0, 1)));
        end
        run_until_done(200);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcsk_symbol_modulator.md
DCSK_SYMBOL_MODULATOR -- requirements
Module: dcsk_symbol_modulator

Interface
REQ-001 SHALL have parameter SPREAD_FACTOR, default 2: chips per half-symbol (reference half, data half).
REQ-002 SHALL have parameter CHIP_W, default 8: signed chip width.
REQ-003 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port chaos_data, input, CHIP_W: signed chaos sample, first-word-fall-through, valid when chaos_empty=0.
REQ-006 SHALL have port chaos_empty, input, 1: chaos source has no sample.
REQ-007 SHALL have port chaos_rd, output, 1: pop strobe, combinational.
REQ-008 SHALL have port bit_valid, input, 1: data bit offered.
REQ-009 SHALL have port bit_in, input, 1: data bit (1 = +reference, 0 = -reference).
REQ-010 SHALL have port bit_ready, output, 1: bit accepted when bit_valid & bit_ready.
REQ-011 SHALL have port chip_out, output, CHIP_W: signed modulated chip, registered.
REQ-012 SHALL have port chip_valid, output, 1: chip_out valid this cycle.
REQ-013 SHALL have port chip_index, output, clog2(2*SPREAD_FACTOR): position of chip_out in symbol.
REQ-014 SHALL have port sym_done, output, 1: one-cycle pulse with last data chip.

Function
REQ-015 SHALL implement FSM states IDLE, REF, DATA.
REQ-016 In IDLE, bit_ready SHALL be 1; on bit_valid, latch bit_in and go to REF.
REQ-017 In REF, chaos_rd SHALL equal ~chaos_empty; each pop stores chaos_data into ref buffer slot k and registers it to chip_out next cycle.
REQ-018 After SPREAD_FACTOR pops in REF, go to DATA; no pops in DATA (chaos_rd=0).
REQ-019 In DATA, emit one chip per cycle from buffer slot k: value if latched bit=1, two's-complement negation if 0.
REQ-020 chip_valid SHALL be 1 exactly on cycles following a pop (REF) or any DATA cycle; chaos_empty in REF stalls, chip_valid=0, no index advance.
REQ-021 chip_index SHALL be 0..SPREAD_FACTOR-1 for reference chips, SPREAD_FACTOR..2*SPREAD_FACTOR-1 for data chips, wrapping to 0 per symbol.
REQ-022 sym_done SHALL pulse with chip_index=2*SPREAD_FACTOR-1; FSM returns to IDLE, bit_ready=1 next cycle (one idle cycle minimum between symbols).
REQ-023 bit_valid outside IDLE SHALL be ignored (bit_ready=0).

Reset
REQ-024 On rstn=0 at clk edge: state IDLE, chip_out=0, chip_valid=0, chip_index=0, sym_done=0, ref buffer cleared, latched bit=0.
REQ-025 Reset mid-symbol SHALL abort the symbol; no partial chips after rstn returns to 1.

Configuration
REQ-026 Macro DCSK_SAT_NEG_EN defined: negation of -2^(CHIP_W-1) SHALL saturate to 2^(CHIP_W-1)-1.
REQ-027 Macro DCSK_SAT_NEG_EN undefined: plain two's-complement negation (-2^(CHIP_W-1) stays -2^(CHIP_W-1)).

Structure
REQ-028 Package dcsk_pkg SHALL hold FSM state enum, default SPREAD_FACTOR/CHIP_W constants, negation function.
REQ-029 Ref buffer SHALL be sub-module dcsk_ref_buffer (SPREAD_FACTOR x CHIP_W, write-index/read-index register file).

Verification (SPREAD_FACTOR=2, CHIP_W=8)
REQ-030 Chaos 10,-20, bit 1 -> chip_out 10,-20,10,-20, chip_index 0,1,2,3, sym_done with 4th chip.
REQ-031 Chaos 10,-20, bit 0 -> chip_out 10,-20,-10,20.
REQ-032 chaos_empty=1 for 3 cycles after first pop -> chip_valid low 3 cycles, chaos_rd low, output sequence unchanged.
REQ-033 Chaos -128,5, bit 0 -> data chips 127,-5 with DCSK_SAT_NEG_EN; -128,-5 without.
REQ-034 rstn=0 during DATA chip 2 -> next cycle chip_valid=0, chip_index=0, bit_ready=1; new symbol correct.
REQ-035 Two bits 1,0 back-to-back with chaos 1,2,3,4 -> 1,2,1,2 then 3,4,-3,-4, one idle cycle between.
